// File: rtl/lshift_pkg.sv
// Shared sizing and skid-buffer state definitions for the saturating left-shift block.
package lshift_pkg;

  localparam int DEF_CHUNK_SIZE    = 4;
  localparam int DEF_NUM_CORES_A   = 4;
  localparam int DEF_NUM_CORES_B   = 1;
  localparam int DEF_TOTAL_MODULES = 2;
  localparam int DEF_WIDTH_OUT     = 16;

  localparam int ELEMENTS_PER_VEC =
    DEF_CHUNK_SIZE * DEF_NUM_CORES_A * DEF_NUM_CORES_B * DEF_TOTAL_MODULES;
  localparam int VECTOR_BITS = DEF_WIDTH_OUT * ELEMENTS_PER_VEC;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic int elements_per_vec(input int chunk, input int cores_a,
                                          input int cores_b, input int modules);
    return chunk * cores_a * cores_b * modules;
  endfunction

endpackage

// File: rtl/sat_lshift_elem.sv
// One signed element: shift left by SHIFT, clamp to the signed range on overflow.
module sat_lshift_elem #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 4
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  // The shift is exact only when the top SHIFT+1 bits are all sign copies.
  logic [SHIFT:0] top_bits;
  assign top_bits = x[WIDTH-1 -: SHIFT+1];
  assign sat      = !((top_bits == '0) || (top_bits == '1));

  always_comb begin
    y = x << SHIFT;
    if (sat) begin
      y = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lshift_sat.sv
// Vector saturating left shift behind a two-entry skid buffer, with per-frame saturation stats.
module lshift_sat
  import lshift_pkg::*;
#(
  parameter int WIDTH_OUT     = DEF_WIDTH_OUT,
  parameter int CHUNK_SIZE    = DEF_CHUNK_SIZE,
  parameter int NUM_CORES_A   = DEF_NUM_CORES_A,
  parameter int NUM_CORES_B   = DEF_NUM_CORES_B,
  parameter int TOTAL_MODULES = DEF_TOTAL_MODULES,
  parameter int TOTAL_INPUT_W = 2,
  parameter int SHIFT_AMT     = 4,
  localparam int N_ELEM   = elements_per_vec(CHUNK_SIZE, NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
  localparam int VEC_BITS = WIDTH_OUT * N_ELEM,
  localparam int N_ALL    = N_ELEM * TOTAL_INPUT_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [TOTAL_INPUT_W-1:0][VEC_BITS-1:0]  in_data,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [TOTAL_INPUT_W-1:0][VEC_BITS-1:0]  out_data,
  output logic                                    out_last,
  output logic [N_ALL-1:0]                        out_sat_mask,
  output logic [15:0]                             frame_sat_count,
  output logic                                    frame_done,
  output logic                                    sat_sticky,
  input  logic                                    clr_sticky
);

  localparam int POP_W = $clog2(N_ALL + 1);

  logic [WIDTH_OUT-1:0]                    elem_y [N_ALL];
  logic [N_ALL-1:0]                        shifted_sat;
  logic [TOTAL_INPUT_W-1:0][VEC_BITS-1:0]  shifted_data;

  for (genvar gi = 0; gi < N_ALL; gi++) begin : g_elem
    localparam int W_IDX = gi / N_ELEM;
    localparam int MSB   = VEC_BITS - 1 - (gi % N_ELEM) * WIDTH_OUT;
    sat_lshift_elem #(.WIDTH(WIDTH_OUT), .SHIFT(SHIFT_AMT)) u_elem (
      .x   (in_data[W_IDX][MSB -: WIDTH_OUT]),
      .y   (elem_y[gi]),
      .sat (shifted_sat[gi])
    );
  end

  always_comb begin
    shifted_data = '0;
    for (int i = 0; i < N_ALL; i++) begin
      shifted_data[i / N_ELEM][VEC_BITS - 1 - (i % N_ELEM) * WIDTH_OUT -: WIDTH_OUT] = elem_y[i];
    end
  end

  skid_state_e state_reg, state_next;
  logic [TOTAL_INPUT_W-1:0][VEC_BITS-1:0] main_data_reg, skid_data_reg;
  logic [N_ALL-1:0] main_mask_reg, skid_mask_reg;
  logic main_last_reg, skid_last_reg, in_ready_reg;
  logic load_main, load_skid, move_skid;
  logic in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = (state_reg != EMPTY) && out_ready;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state_reg)
      EMPTY: if (in_xfer) begin
        state_next = ONE;
        load_main  = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_next = ONE;
        move_skid  = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b0;
      main_data_reg <= '0;
      skid_data_reg <= '0;
      main_mask_reg <= '0;
      skid_mask_reg <= '0;
      main_last_reg <= 1'b0;
      skid_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
      if (load_main) begin
        main_data_reg <= shifted_data;
        main_mask_reg <= shifted_sat;
        main_last_reg <= in_last;
      end else if (move_skid) begin
        main_data_reg <= skid_data_reg;
        main_mask_reg <= skid_mask_reg;
        main_last_reg <= skid_last_reg;
      end
      if (load_skid) begin
        skid_data_reg <= shifted_data;
        skid_mask_reg <= shifted_sat;
        skid_last_reg <= in_last;
      end
    end
  end

  // Saturation statistics, accumulated only on accepted output beats.
  logic [POP_W-1:0] sat_pop;
  logic [16:0]      count_sum;
  logic [15:0]      count_reg, count_next, frame_count_reg;
  logic             frame_done_reg, sticky_reg;

  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < N_ALL; i++) begin
      sat_pop = sat_pop + POP_W'(main_mask_reg[i]);
    end
    count_sum  = {1'b0, count_reg} + 17'(sat_pop);
    count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      frame_count_reg <= '0;
      frame_done_reg  <= 1'b0;
      sticky_reg      <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (out_xfer) begin
        if (main_last_reg) begin
          frame_count_reg <= count_next;
          frame_done_reg  <= 1'b1;
          count_reg       <= '0;
        end else begin
          count_reg <= count_next;
        end
      end
      if (out_xfer && (main_mask_reg != '0)) begin
        sticky_reg <= 1'b1;
      end else if (clr_sticky) begin
        sticky_reg <= 1'b0;
      end
    end
  end

  assign in_ready        = in_ready_reg;
  assign out_valid       = (state_reg != EMPTY);
  assign out_data        = main_data_reg;
  assign out_last        = main_last_reg;
  assign out_sat_mask    = main_mask_reg;
  assign frame_sat_count = frame_count_reg;
  assign frame_done      = frame_done_reg;
  assign sat_sticky      = sticky_reg;

endmodule

// File: tb/tb_lshift_sat.sv
// Directed bench for lshift_sat at WIDTH_OUT=16, SHIFT_AMT=4 with hand-computed expectations.
module tb_lshift_sat;

  localparam int W   = 16;
  localparam int NE  = 32;
  localparam int TIW = 2;
  localparam int VB  = W * NE;

  typedef logic [TIW-1:0][VB-1:0] beat_t;

  logic        clk, rst, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_last, frame_done, sat_sticky, clr_sticky;
  beat_t       in_data, out_data;
  logic [63:0] out_sat_mask;
  logic [15:0] frame_sat_count;

  int nvec = 0;
  int nerr = 0;

  lshift_sat #(.WIDTH_OUT(16), .SHIFT_AMT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_sat_mask    (out_sat_mask),
    .frame_sat_count (frame_sat_count),
    .frame_done      (frame_done),
    .sat_sticky      (sat_sticky),
    .clr_sticky      (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required $finish");
    $fatal(1, "timeout");
  end

  function automatic beat_t put(beat_t d, int w, int e, logic [15:0] v);
    d[w][VB-1-e*W -: W] = v;
    return d;
  endfunction

  // k saturating elements (0x0800) in vector 0, plus one exact element in vector 1.
  function automatic beat_t nsat(int k);
    beat_t d = '0;
    for (int i = 0; i < k; i++) d = put(d, 0, i, 16'h0800);
    d = put(d, 1, 31, 16'h0001);
    return d;
  endfunction

  function automatic beat_t nsat_exp(int k);
    beat_t d = '0;
    for (int i = 0; i < k; i++) d = put(d, 0, i, 16'h7FFF);
    d = put(d, 1, 31, 16'h0010);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    $display("vector %0d %s: observed %0h expected %0h", nvec, tag, obs, exp);
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(string tag, beat_t obs, beat_t exp);
    int fw = -1;
    int fe = -1;
    for (int w = 0; w < TIW; w++)
      for (int e = 0; e < NE; e++)
        if (fw < 0 && obs[w][VB-1-e*W -: W] !== exp[w][VB-1-e*W -: W]) begin
          fw = w;
          fe = e;
        end
    nvec++;
    $display("vector %0d %s: beat compare", nvec, tag);
    assert (obs === exp) else begin
      nerr++;
      if (fw < 0) begin
        fw = 0;
        fe = 0;
      end
      $error("FAIL %s: vec %0d elem %0d observed %h expected %h", tag, fw, fe,
             obs[fw][VB-1-fe*W -: W], exp[fw][VB-1-fe*W -: W]);
    end
  endtask

  initial begin
    beat_t d, e;
    int sent, got;
    logic acc_in, acc_out;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check_beat("rst_out_data", out_data, '0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_mask", out_sat_mask, 64'd0);
    check("rst_frame_count", 64'(frame_sat_count), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_sticky", 64'(sat_sticky), 64'd0);

    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Exact shifts: 0x0123, 0xFFFF, 0xF800
    out_ready = 1'b1;
    d = '0; d = put(d, 0, 0, 16'h0123); d = put(d, 0, 1, 16'hFFFF); d = put(d, 0, 2, 16'hF800);
    e = '0; e = put(e, 0, 0, 16'h1230); e = put(e, 0, 1, 16'hFFF0); e = put(e, 0, 2, 16'h8000);
    in_data = d; in_valid = 1'b1;
    tick();
    check("latency1_valid", 64'(out_valid), 64'd1);
    check_beat("exact_data", out_data, e);
    check("exact_mask", out_sat_mask, 64'd0);

    // Saturating: 0x0800 -> 0x7FFF (bit 0), 0xF7FF -> 0x8000 (vec 1 elem 1, bit 33)
    d = '0; d = put(d, 0, 0, 16'h0800); d = put(d, 1, 1, 16'hF7FF);
    e = '0; e = put(e, 0, 0, 16'h7FFF); e = put(e, 1, 1, 16'h8000);
    in_data = d; in_last = 1'b1;
    tick();
    check_beat("sat_data", out_data, e);
    check("sat_mask", out_sat_mask, 64'h0000_0002_0000_0001);
    check("sat_last", 64'(out_last), 64'd1);
    check("sticky_clean", 64'(sat_sticky), 64'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("sticky_set", 64'(sat_sticky), 64'd1);
    check("frame1_count", 64'(frame_sat_count), 64'd2);
    check("frame1_done", 64'(frame_done), 64'd1);
    check("drained_valid", 64'(out_valid), 64'd0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("sticky_cleared", 64'(sat_sticky), 64'd0);
    check("done_single_pulse", 64'(frame_done), 64'd0);

    // Backpressure: out_ready low for 3 cycles with continuous input
    sent = 0; got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 5);
      in_data   = put(beat_t'(0), 1, 5, 16'(16'h0010 + sent));
      acc_in    = in_valid && in_ready;
      acc_out   = out_valid && out_ready;
      if (out_valid && !out_ready)
        check_beat("hold_stable", out_data, put(beat_t'(0), 1, 5, 16'(16'h0100 + 16 * got)));
      if (acc_out) begin
        check_beat("order", out_data, put(beat_t'(0), 1, 5, 16'(16'h0100 + 16 * got)));
        got++;
      end
      tick();
      if (acc_in) sent++;
      if (c == 1) check("ready_low_two_held", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("drain_count", 64'(got), 64'd5);

    // Frame of 2+0+5 saturated elements; clr_sticky vs saturating transfer
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = nsat(2); in_last = 1'b0;
    tick();
    check("f0_mask", out_sat_mask, 64'h3);
    check_beat("f0_data", out_data, nsat_exp(2));
    in_data = nsat(0);
    tick();
    check("f1_mask", out_sat_mask, 64'h0);
    check("f0_sticky", 64'(sat_sticky), 64'd1);
    in_data = nsat(5); in_last = 1'b1; clr_sticky = 1'b1;
    tick();
    check("f2_mask", out_sat_mask, 64'h1F);
    check("f2_last", 64'(out_last), 64'd1);
    check("clr_nonsat", 64'(sat_sticky), 64'd0);
    check("no_early_done", 64'(frame_done), 64'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    clr_sticky = 1'b0;
    check("set_beats_clr", 64'(sat_sticky), 64'd1);
    check("frame2_count", 64'(frame_sat_count), 64'd7);
    check("frame2_done", 64'(frame_done), 64'd1);
    in_valid = 1'b1; in_data = nsat(3); in_last = 1'b1;
    tick();
    check("frame2_done_off", 64'(frame_done), 64'd0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("frame3_from_zero", 64'(frame_sat_count), 64'd3);

    // Reset while TWO mid-frame with a partial count pending
    in_valid = 1'b1; in_data = nsat(1);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = nsat(3);
    tick();
    in_data = nsat(4);
    tick();
    check("two_full_ready", 64'(in_ready), 64'd0);
    check("two_full_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check_beat("mid_rst_data", out_data, '0);
    check("mid_rst_mask", out_sat_mask, 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_count", 64'(frame_sat_count), 64'd0);
    check("mid_rst_sticky", 64'(sat_sticky), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = nsat(1); in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("post_rst_count", 64'(frame_sat_count), 64'd1);
    check("post_rst_done", 64'(frame_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lshift_sat.md
LSHIFT_SAT -- requirements
Module: lshift_sat

Interface
REQ-001 SHALL have parameter WIDTH_OUT, default 16, element width (signed two's complement).
REQ-002 SHALL have parameters CHUNK_SIZE=4, NUM_CORES_A=4, NUM_CORES_B=1, TOTAL_MODULES=2; ELEMENTS_PER_VEC = their product; VECTOR_BITS = WIDTH_OUT*ELEMENTS_PER_VEC.
REQ-003 SHALL have parameter TOTAL_INPUT_W, default 2, vectors per beat.
REQ-004 SHALL have parameter SHIFT_AMT, default 4, left-shift distance (1..WIDTH_OUT-1).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream beat valid.
REQ-008 in_ready  out  1  block can accept a beat.
REQ-009 in_data  in  VECTOR_BITS x [TOTAL_INPUT_W]  packed elements; element e at bits [VECTOR_BITS-1-e*WIDTH_OUT -: WIDTH_OUT].
REQ-010 in_last  in  1  beat ends a frame.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 out_data  out  VECTOR_BITS x [TOTAL_INPUT_W]  shifted elements, same packing.
REQ-014 out_last  out  1  in_last carried with its beat.
REQ-015 out_sat_mask  out  ELEMENTS_PER_VEC*TOTAL_INPUT_W  per-element saturation flag of current out beat; bit w*ELEMENTS_PER_VEC+e.
REQ-016 frame_sat_count  out  16  saturated elements in last completed frame.
REQ-017 frame_done  out  1  one-cycle pulse when frame_sat_count updates.
REQ-018 sat_sticky  out  1  any saturation since last clear; clr_sticky  in  1  clears it.

Function
REQ-019 Each element SHALL produce x*2^SHIFT_AMT if representable in signed WIDTH_OUT, else 2^(WIDTH_OUT-1)-1 for x>0 or -2^(WIDTH_OUT-1) for x<0, flagging saturation.
REQ-020 Transfer SHALL occur on valid&&ready at a rising edge; data/last/mask SHALL remain stable while out_valid&&!out_ready.
REQ-021 Latency SHALL be exactly 1 cycle from input transfer to out_valid with no backpressure; throughput one beat/cycle.
REQ-022 Buffering SHALL be a 2-entry skid (main + skid registers) with states EMPTY, ONE, TWO.
REQ-023 EMPTY: input accepted -> ONE. ONE: in&&out transfer -> ONE; in only -> TWO; out only -> EMPTY. TWO: out transfer -> ONE (skid moves to main); no input accepted.
REQ-024 in_ready SHALL be a register output, high exactly when state != TWO.
REQ-025 Beat order SHALL be preserved; no beat dropped or duplicated.
REQ-026 Saturation counter SHALL add popcount(out_sat_mask) on each output transfer, clamping at 0xFFFF.
REQ-027 On output transfer with out_last, frame_sat_count SHALL load counter+that beat's popcount (clamped), frame_done pulse next cycle... same cycle as register update, counter SHALL restart at 0.
REQ-028 sat_sticky SHALL set on any output transfer with nonzero mask; if set and clr_sticky coincide, set SHALL win.

Reset
REQ-029 While rst high at an edge: state EMPTY, in_ready 0, out_valid 0, out_data 0, out_last 0, out_sat_mask 0, counter 0, frame_sat_count 0, frame_done 0, sat_sticky 0.
REQ-030 in_ready SHALL rise the cycle after rst deasserts; reset mid-frame SHALL discard buffered beats and partial counts.

Structure
REQ-031 ELEMENTS_PER_VEC, VECTOR_BITS and the skid state enum SHALL live in shared package lshift_pkg.
REQ-032 Per-element shift/saturate SHALL be one combinational sub-module sat_lshift_elem, generated per element.

Verification (WIDTH_OUT=16, SHIFT_AMT=4)
REQ-033 Inputs 0x0123, 0xFFFF, 0xF800 -> 0x1230, 0xFFF0, 0x8000, mask bits 0, out 1 cycle later.
REQ-034 Inputs 0x0800, 0xF7FF -> 0x7FFF, 0x8000, mask bits 1, sat_sticky 1.
REQ-035 Continuous in_valid, out_ready low 3 cycles -> in_ready low after 2 beats held, all beats out in order after release.
REQ-036 3-beat frame with 2+0+5 saturated elements -> frame_sat_count 7, single frame_done pulse, next frame starts at 0.
REQ-037 rst asserted with state TWO mid-frame -> all outputs 0 next cycle, next frame count unaffected.
REQ-038 clr_sticky concurrent with saturating transfer -> sat_sticky stays 1.
